// File: rtl/note_pkg.sv
// Shared note definitions: one-hot codes, pitch constants, half-period math.
// Used by both the tone player and the microphone note detector.
package note_pkg;

  localparam int w_note = 12;

  localparam logic [w_note-1:0] note_c  = 12'h800;
  localparam logic [w_note-1:0] note_cs = 12'h400;
  localparam logic [w_note-1:0] note_d  = 12'h200;
  localparam logic [w_note-1:0] note_ds = 12'h100;
  localparam logic [w_note-1:0] note_e  = 12'h080;
  localparam logic [w_note-1:0] note_f  = 12'h040;
  localparam logic [w_note-1:0] note_fs = 12'h020;
  localparam logic [w_note-1:0] note_g  = 12'h010;
  localparam logic [w_note-1:0] note_gs = 12'h008;
  localparam logic [w_note-1:0] note_a  = 12'h004;
  localparam logic [w_note-1:0] note_as = 12'h002;
  localparam logic [w_note-1:0] note_b  = 12'h001;

  localparam int f100_c  = 26163;
  localparam int f100_cs = 27718;
  localparam int f100_d  = 29366;
  localparam int f100_ds = 31113;
  localparam int f100_e  = 32963;
  localparam int f100_f  = 34923;
  localparam int f100_fs = 36999;
  localparam int f100_g  = 39200;
  localparam int f100_gs = 41530;
  localparam int f100_a  = 44000;
  localparam int f100_as = 46616;
  localparam int f100_b  = 49388;

  typedef enum logic [1:0] {
    st_idle,
    st_play,
    st_rest
  } state_t;

  // 64-bit math: clk_mhz * 1e8 overflows 32 bits at 50 MHz.
  function automatic logic [19:0] half_period(
    input int clk_mhz,
    input int freq_100
  );
    longint hp;
    hp = (longint'(clk_mhz) * 64'sd100000000)
       / (64'sd2 * longint'(freq_100));
    if (hp < 64'sd1) hp = 64'sd1;
    if (hp > 64'sd1048575) hp = 64'sd1048575;
    return hp[19:0];
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave phase generator: toggles phase every hp enabled cycles.
// Ports: clk, rst, restart (clear count+phase), en, hp, phase, wrap.
module tone_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        en,
  input  logic [19:0] hp,
  output logic        phase,
  output logic        wrap
);

  logic [19:0] cnt;

  assign wrap = en && (cnt == hp - 20'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else if (en) begin
      cnt <= cnt + 20'd1;
    end
  end

endmodule

// File: rtl/note_tone_player.sv
// Plays timed note requests (valid/ready, one-entry buffer) as a square wave.
// Ports: clk, rst, req_*, sound, cur_note, busy, note_done.
module note_tone_player
  import note_pkg::*;
#(
  parameter int                 clk_mhz   = 50,
  parameter logic signed [15:0] amplitude = 16'sd8192,
  parameter int                 w_dur     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [w_note-1:0]        req_note,
  input  logic [1:0]               req_octave,
  input  logic [w_dur-1:0]         req_dur_ms,
  output logic signed [15:0]       sound,
  output logic [w_note-1:0]        cur_note,
  output logic                     busy,
  output logic                     note_done
);

  localparam logic [19:0] hp_tab [12] = '{
    half_period(clk_mhz, f100_c),
    half_period(clk_mhz, f100_cs),
    half_period(clk_mhz, f100_d),
    half_period(clk_mhz, f100_ds),
    half_period(clk_mhz, f100_e),
    half_period(clk_mhz, f100_f),
    half_period(clk_mhz, f100_fs),
    half_period(clk_mhz, f100_g),
    half_period(clk_mhz, f100_gs),
    half_period(clk_mhz, f100_a),
    half_period(clk_mhz, f100_as),
    half_period(clk_mhz, f100_b)
  };

  localparam logic [19:0] pre_max = 20'(clk_mhz * 1000 - 1);

  state_t            state;
  logic [w_note-1:0] buf_note;
  logic [1:0]        buf_oct;
  logic [w_dur-1:0]  buf_dur;
  logic              buf_full;
  logic [w_dur-1:0]  act_dur;
  logic [19:0]       hp_act;
  logic [19:0]       pre;
  logic [w_dur-1:0]  ms;

  logic [19:0] hp_base;
  logic [19:0] hp_sh;
  logic [19:0] hp_sel;
  logic        pre_wrap;
  logic        finish;
  logic        load;
  logic        acc;
  logic        phase;
  logic        wrap;

  always_comb begin
    case (buf_note)
      note_c:  hp_base = hp_tab[0];
      note_cs: hp_base = hp_tab[1];
      note_d:  hp_base = hp_tab[2];
      note_ds: hp_base = hp_tab[3];
      note_e:  hp_base = hp_tab[4];
      note_f:  hp_base = hp_tab[5];
      note_fs: hp_base = hp_tab[6];
      note_g:  hp_base = hp_tab[7];
      note_gs: hp_base = hp_tab[8];
      note_a:  hp_base = hp_tab[9];
      note_as: hp_base = hp_tab[10];
      note_b:  hp_base = hp_tab[11];
      default: hp_base = 20'd1;
    endcase
    hp_sh  = hp_base >> buf_oct;
    hp_sel = (hp_sh == 20'd0) ? 20'd1 : hp_sh;
  end

  assign pre_wrap = (pre == pre_max);
  assign finish   = (state != st_idle) && pre_wrap
                 && (ms == act_dur - w_dur'(1));
  // The buffer feeds the active register from idle or straight on finish.
  assign load     = buf_full && ((state == st_idle) || finish);
  assign acc      = req_valid && req_ready;

  tone_divider u_div (
    .clk     (clk),
    .rst     (rst),
    .restart (load),
    .en      (state == st_play),
    .hp      (hp_act),
    .phase   (phase),
    .wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= st_idle;
      buf_note  <= '0;
      buf_oct   <= '0;
      buf_dur   <= '0;
      buf_full  <= 1'b0;
      act_dur   <= '0;
      hp_act    <= 20'd1;
      pre       <= '0;
      ms        <= '0;
      req_ready <= 1'b1;
      sound     <= '0;
      cur_note  <= '0;
      busy      <= 1'b0;
      note_done <= 1'b0;
    end else begin
      note_done <= finish;
      if (acc) begin
        buf_note <= req_note;
        buf_oct  <= req_octave;
        buf_dur  <= req_dur_ms;
      end
      buf_full  <= acc || (buf_full && !load);
      req_ready <= !(acc || (buf_full && !load));
      if (load) begin
        pre     <= '0;
        ms      <= '0;
        act_dur <= buf_dur;
        hp_act  <= hp_sel;
        if (buf_dur == '0) begin
          // Zero-length entry: report it done without sounding.
          state     <= st_idle;
          sound     <= '0;
          cur_note  <= '0;
          busy      <= 1'b0;
          note_done <= 1'b1;
        end else if ($onehot(buf_note)) begin
          state    <= st_play;
          sound    <= amplitude;
          cur_note <= buf_note;
          busy     <= 1'b1;
        end else begin
          state    <= st_rest;
          sound    <= '0;
          cur_note <= '0;
          busy     <= 1'b1;
        end
      end else if (finish) begin
        state    <= st_idle;
        sound    <= '0;
        cur_note <= '0;
        busy     <= 1'b0;
      end else if (state != st_idle) begin
        pre <= pre_wrap ? 20'd0 : pre + 20'd1;
        if (pre_wrap) ms <= ms + w_dur'(1);
        // phase is the pre-toggle value; new phase 1 means negative half.
        if (state == st_play && wrap)
          sound <= phase ? amplitude : -amplitude;
      end
    end
  end

endmodule

// File: tb/tb_note_tone_player.sv
// Scoreboard bench for note_tone_player at clk_mhz=1.
// Requests push expected entries; each test pops and checks the output.
module tb_note_tone_player;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [11:0]        req_note = '0;
  logic [1:0]         req_octave = '0;
  logic [11:0]        req_dur_ms = '0;
  logic signed [15:0] sound;
  logic [11:0]        cur_note;
  logic               busy;
  logic               note_done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int loud_cnt = 0;

  typedef struct {
    logic [11:0] note;
    int          hp;
    int          dur;
  } exp_t;

  exp_t sb[$];

  note_tone_player #(
    .clk_mhz   (1),
    .amplitude (16'sd8192),
    .w_dur     (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_note   (req_note),
    .req_octave (req_octave),
    .req_dur_ms (req_dur_ms),
    .sound      (sound),
    .cur_note   (cur_note),
    .busy       (busy),
    .note_done  (note_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (note_done === 1'b1) done_cnt++;
    if (sound !== 16'sd0) loud_cnt++;
  end

  function automatic int model_hp(logic [11:0] n, logic [1:0] o);
    int fr [12] = '{49388, 46616, 44000, 41530, 39200, 36999,
                    34923, 32963, 31113, 29366, 27718, 26163};
    int h;
    h = 1;
    for (int i = 0; i < 12; i++)
      if (n[i]) h = 100000000 / (2 * fr[i]);
    h = h >> o;
    if (h < 1) h = 1;
    return h;
  endfunction

  function automatic int exp_snd(int hp, int t);
    return ((t / hp) % 2 == 0) ? 8192 : -8192;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send(input logic [11:0] n, input logic [1:0] o,
                      input int d);
    exp_t e;
    bit rdy;
    bit ok;
    ok = 1'b0;
    req_note = n;
    req_octave = o;
    req_dur_ms = d[11:0];
    req_valid = 1'b1;
    for (int k = 0; k < 10000 && !ok; k++) begin
      rdy = req_ready;
      step();
      ok = rdy;
    end
    req_valid = 1'b0;
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $display("FAIL send_accept: got %0b want 1", ok);
    end
    e.note = n;
    e.hp = model_hp(n, o);
    e.dur = d;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready: got %b want 1", req_ready);
    end
    total++;
    if (sound !== 16'sd0) begin
      bad++; $display("FAIL rst_sound: got %0d want 0", sound);
    end
    total++;
    if (cur_note !== 12'h000 || busy !== 1'b0 || note_done !== 1'b0) begin
      bad++;
      $display("FAIL rst_state: cur=%h busy=%b done=%b want 000 0 0",
               cur_note, busy, note_done);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_tone();
    exp_t e;
    int errs;
    int first;
    int s;
    send(12'h004, 2'd0, 3);
    e = sb.pop_front();
    step();
    total++;
    if (sound !== 16'sd8192 || busy !== 1'b1) begin
      bad++;
      $display("FAIL tone_start: sound=%0d busy=%b want 8192 1",
               sound, busy);
    end
    errs = 0;
    first = -1;
    for (int t = 0; t < e.dur * 1000; t++) begin
      s = sound;
      if (s != exp_snd(e.hp, t) || cur_note !== e.note
          || busy !== 1'b1 || note_done !== 1'b0) errs++;
      if (first < 0 && s != 8192) first = t;
      step();
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL tone_wave: got %0d bad cycles want 0", errs);
    end
    total++;
    if (first !== 1136) begin
      bad++; $display("FAIL tone_hp: got %0d want 1136", first);
    end
    total++;
    if (note_done !== 1'b1 || sound !== 16'sd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tone_end: done=%b sound=%0d busy=%b want 1 0 0",
               note_done, sound, busy);
    end
    step();
    total++;
    if (note_done !== 1'b0 || cur_note !== 12'h000) begin
      bad++;
      $display("FAIL tone_pulse: done=%b cur=%h want 0 000",
               note_done, cur_note);
    end
  endtask

  task automatic test_octave();
    logic [1:0] oct [2] = '{2'd1, 2'd0};
    int dur [2] = '{1, 2};
    int want [2] = '{955, 1911};
    exp_t e;
    int errs;
    int first;
    int s;
    for (int c = 0; c < 2; c++) begin
      send(12'h800, oct[c], dur[c]);
      e = sb.pop_front();
      step();
      errs = 0;
      first = -1;
      for (int t = 0; t < e.dur * 1000; t++) begin
        s = sound;
        if (s != exp_snd(e.hp, t) || cur_note !== 12'h800) errs++;
        if (first < 0 && s != 8192) first = t;
        step();
      end
      total++;
      if (first !== want[c]) begin
        bad++;
        $display("FAIL oct%0d_hp: got %0d want %0d", oct[c], first, want[c]);
      end
      total++;
      if (errs !== 0) begin
        bad++;
        $display("FAIL oct%0d_wave: got %0d bad cycles want 0", oct[c], errs);
      end
      total++;
      if (note_done !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL oct%0d_end: done=%b busy=%b want 1 0",
                 oct[c], note_done, busy);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1;
    exp_t e2;
    int errs;
    int s;
    send(12'h080, 2'd0, 2);
    total++;
    if (req_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_full: ready=%b want 0", req_ready);
    end
    send(12'h010, 2'd0, 2);
    e1 = sb.pop_front();
    errs = 0;
    for (int t = 1; t < e1.dur * 1000; t++) begin
      s = sound;
      if (s != exp_snd(e1.hp, t) || cur_note !== e1.note
          || req_ready !== 1'b0) errs++;
      step();
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL b2b_first: got %0d bad cycles want 0", errs);
    end
    e2 = sb.pop_front();
    total++;
    if (note_done !== 1'b1 || sound !== 16'sd8192
        || cur_note !== e2.note || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_join: done=%b sound=%0d cur=%h busy=%b want 1 8192 %h 1",
               note_done, sound, cur_note, busy, e2.note);
    end
    errs = 0;
    for (int t = 0; t < e2.dur * 1000; t++) begin
      s = sound;
      if (s != exp_snd(e2.hp, t) || cur_note !== e2.note
          || req_ready !== 1'b1) errs++;
      step();
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL b2b_second: got %0d bad cycles want 0", errs);
    end
    total++;
    if (note_done !== 1'b1 || busy !== 1'b0 || sound !== 16'sd0) begin
      bad++;
      $display("FAIL b2b_end: done=%b busy=%b sound=%0d want 1 0 0",
               note_done, busy, sound);
    end
    step();
  endtask

  task automatic test_rest();
    logic [11:0] pat [2] = '{12'h000, 12'h0C0};
    exp_t e;
    int errs;
    int d0;
    for (int c = 0; c < 2; c++) begin
      d0 = done_cnt;
      send(pat[c], 2'd0, 2);
      e = sb.pop_front();
      step();
      errs = 0;
      for (int t = 0; t < e.dur * 1000; t++) begin
        if (sound !== 16'sd0 || cur_note !== 12'h000 || busy !== 1'b1)
          errs++;
        step();
      end
      total++;
      if (errs !== 0) begin
        bad++;
        $display("FAIL rest_%h: got %0d bad cycles want 0", pat[c], errs);
      end
      total++;
      if (busy !== 1'b0) begin
        bad++; $display("FAIL rest_%h_end: busy=%b want 0", pat[c], busy);
      end
      step();
      total++;
      if (done_cnt - d0 !== 1) begin
        bad++;
        $display("FAIL rest_%h_done: got %0d pulses want 1",
                 pat[c], done_cnt - d0);
      end
    end
  endtask

  task automatic test_dur0();
    exp_t e;
    int d0;
    int l0;
    int n;
    d0 = done_cnt;
    l0 = loud_cnt;
    send(12'h004, 2'd0, 0);
    e = sb.pop_front();
    send(12'h200, 2'd0, 1);
    e = sb.pop_front();
    total++;
    if (done_cnt - d0 !== 1 || loud_cnt - l0 !== 0) begin
      bad++;
      $display("FAIL dur0_skip: pulses=%0d loud=%0d want 1 0",
               done_cnt - d0, loud_cnt - l0);
    end
    step();
    total++;
    if (sound !== 16'sd8192 || cur_note !== e.note) begin
      bad++;
      $display("FAIL dur0_next: sound=%0d cur=%h want 8192 %h",
               sound, cur_note, e.note);
    end
    n = 0;
    while (busy === 1'b1 && n < 1100) begin
      n++;
      step();
    end
    total++;
    if (n !== 1000) begin
      bad++; $display("FAIL dur0_len: got %0d want 1000", n);
    end
    step();
  endtask

  task automatic test_reset_mid();
    send(12'h800, 2'd0, 3);
    send(12'h080, 2'd0, 1);
    sb.delete();
    repeat (499) step();
    total++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre: busy=%b ready=%b want 1 0", busy, req_ready);
    end
    rst = 1'b1;
    step();
    total++;
    if (sound !== 16'sd0 || busy !== 1'b0 || req_ready !== 1'b1
        || cur_note !== 12'h000) begin
      bad++;
      $display("FAIL mid_rst: sound=%0d busy=%b ready=%b cur=%h want 0 0 1 000",
               sound, busy, req_ready, cur_note);
    end
    rst = 1'b0;
    repeat (3) step();
    total++;
    if (busy !== 1'b0 || sound !== 16'sd0) begin
      bad++;
      $display("FAIL mid_drop: busy=%b sound=%0d want 0 0", busy, sound);
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_octave();
    test_back_to_back();
    test_rest();
    test_dur0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
